patt_serializer: RTL and testbench

//  Parallel-to-serial front end for the 1101 pattern detector. Accepts WIDTH-bit words over a

---
 rtl/patt_serializer.sv | 196 +++++++++++++++++++
 tb/tb_patt_serializer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/patt_serializer.sv
// ---------------------------------------------------------------------------
// patt_serializer
//
// Parallel-to-serial front end for the 1101 pattern detector. WIDTH-bit words
// are accepted over a valid/ready handshake and sent one bit per CLK on x.
// x_valid, sof and last qualify each bit for downstream logging. The detector
// has no valid input, so x rests at IDLE_BIT whenever no bit is being sent.
//
// Configuration macro:
//   SER_PARITY_EN  when defined, each frame ends with one even-parity bit
//                  (x = ^word) and lasts WIDTH+1 cycles; when undefined the
//                  parity state is not built and a frame lasts WIDTH cycles.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: din[WIDTH-1] is sent first, 0: din[0] is sent first
//   IDLE_BIT   value on x while x_valid = 0
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   asynchronous reset, active-high
//   din        in   parallel word, sampled only on accept
//   din_valid  in   producer has a word on din
//   din_ready  out  word can be accepted this cycle (state only, low in reset)
//   x          out  serial bit, registered
//   x_valid    out  x carries a data or parity bit this cycle
//   sof        out  current bit is the first bit of a word
//   last       out  current bit is the final bit of the frame
//   busy       out  state is not IDLE
// ---------------------------------------------------------------------------
module patt_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             sof,
    output logic             last,
    output logic             busy
);

    // Counter only has to reach WIDTH-1 and is reloaded on every accept.
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT
`ifdef SER_PARITY_EN
        ,
        S_PARITY
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   sreg_q,  sreg_d;
    logic               x_q,       x_d;
    logic               x_valid_q, x_valid_d;
    logic               sof_q,     sof_d;
    logic               last_q,    last_d;
`ifdef SER_PARITY_EN
    logic               par_q,     par_d;
`endif

    logic ready;
    logic accept;
    logic last_data;
    logic next_bit;

    // The bit on x is cnt_q; the data phase ends when cnt_q reaches WIDTH-1.
    assign last_data = (cnt_q == CNT_W'(WIDTH - 1));

    // sreg_q holds the bits still to be sent, aligned so the next one sits
    // at the outgoing end.
    assign next_bit  = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

    // Ready depends on state only; the frame's final cycle is also ready so a
    // waiting word follows without a bubble.
    always_comb begin
        ready = 1'b0;
        unique case (state_q)
            S_IDLE:   ready = 1'b1;
`ifdef SER_PARITY_EN
            S_SHIFT:  ready = 1'b0;
            S_PARITY: ready = 1'b1;
`else
            S_SHIFT:  ready = last_data;
`endif
            default:  ready = 1'b0;
        endcase
    end

    assign din_ready = ready && !RST;
    assign accept    = din_valid && din_ready;

    // Next-state and registered-output logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        sreg_d    = sreg_q;
        x_d       = IDLE_BIT;
        x_valid_d = 1'b0;
        sof_d     = 1'b0;
        last_d    = 1'b0;
`ifdef SER_PARITY_EN
        par_d     = par_q;
`endif

        // Continue the current frame when one is in progress.
        case (state_q)
            S_SHIFT: begin
                if (!last_data) begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    x_d       = next_bit;
                    x_valid_d = 1'b1;
                    sreg_d    = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
`ifndef SER_PARITY_EN
                    last_d    = (cnt_q == CNT_W'(WIDTH - 2));
`endif
                end else begin
`ifdef SER_PARITY_EN
                    state_d   = S_PARITY;
                    x_d       = par_q;
                    x_valid_d = 1'b1;
                    last_d    = 1'b1;
`else
                    state_d   = S_IDLE;
`endif
                end
            end
`ifdef SER_PARITY_EN
            S_PARITY: state_d = S_IDLE;
`endif
            S_IDLE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // An accept can only happen in IDLE or the frame's final cycle, so it
        // overrides whatever the frame logic above chose.
        if (accept) begin
            state_d   = S_SHIFT;
            cnt_d     = '0;
            x_d       = MSB_FIRST ? din[WIDTH-1] : din[0];
            x_valid_d = 1'b1;
            sof_d     = 1'b1;
            last_d    = 1'b0;
            sreg_d    = MSB_FIRST ? (din << 1) : (din >> 1);
`ifdef SER_PARITY_EN
            par_d     = ^din;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sreg_q    <= '0;
            x_q       <= IDLE_BIT;
            x_valid_q <= 1'b0;
            sof_q     <= 1'b0;
            last_q    <= 1'b0;
`ifdef SER_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sreg_q    <= sreg_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            sof_q     <= sof_d;
            last_q    <= last_d;
`ifdef SER_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign sof     = sof_q;
    assign last    = last_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_patt_serializer.sv
// ---------------------------------------------------------------------------
// tb_patt_serializer
//
// Directed bench for patt_serializer. Two instances share CLK/RST: u_msb
// (MSB_FIRST=1) and u_lsb (MSB_FIRST=0), both WIDTH=8, IDLE_BIT=0.
// Expected bit streams come from the hand-chosen words; the parity frame
// is exercised only when SER_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_patt_serializer;

    localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic [WIDTH-1:0] din_m, din_l;
    logic             dv_m, dv_l;
    logic             rdy_m, x_m, xv_m, sof_m, last_m, busy_m;
    logic             rdy_l, x_l, xv_l, sof_l, last_l, busy_l;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    patt_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .CLK(CLK), .RST(RST), .din(din_m), .din_valid(dv_m), .din_ready(rdy_m),
        .x(x_m), .x_valid(xv_m), .sof(sof_m), .last(last_m), .busy(busy_m)
    );

    patt_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .CLK(CLK), .RST(RST), .din(din_l), .din_valid(dv_l), .din_ready(rdy_l),
        .x(x_l), .x_valid(xv_l), .sof(sof_l), .last(last_l), .busy(busy_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // sel = 1 addresses the LSB-first instance.
    task automatic drive(input bit sel, input logic [WIDTH-1:0] w, input logic v);
        if (sel) begin din_l = w; dv_l = v; end
        else     begin din_m = w; dv_m = v; end
    endtask

    task automatic sample(input bit sel, output logic xs, output logic xv, output logic sf,
                          output logic ls, output logic bz, output logic rd);
        if (sel) begin xs = x_l; xv = xv_l; sf = sof_l; ls = last_l; bz = busy_l; rd = rdy_l; end
        else     begin xs = x_m; xv = xv_m; sf = sof_m; ls = last_m; bz = busy_m; rd = rdy_m; end
    endtask

    // Called just after a negedge at which an accept has been set up. Checks
    // every bit of the frame of w; in its first cycle it sets up the follow-on
    // word (chain=1) or drops din_valid (chain=0).
    task automatic expect_frame(input bit sel, input logic [WIDTH-1:0] w, input bit chain,
                                input logic [WIDTH-1:0] next_w, input string tag);
        logic xs, xv, sf, ls, bz, rd, eb;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge CLK);
            if (i == 0) drive(sel, next_w, chain);
            if (i >= WIDTH)  eb = ^w;
            else if (sel)    eb = w[i];
            else             eb = w[WIDTH-1-i];
            sample(sel, xs, xv, sf, ls, bz, rd);
            check($sformatf("%s.x[%0d]",     tag, i), xs, eb);
            check($sformatf("%s.valid[%0d]", tag, i), xv, 1'b1);
            check($sformatf("%s.sof[%0d]",   tag, i), sf, (i == 0));
            check($sformatf("%s.last[%0d]",  tag, i), ls, (i == FRAME-1));
            check($sformatf("%s.busy[%0d]",  tag, i), bz, 1'b1);
            check($sformatf("%s.ready[%0d]", tag, i), rd, (i == FRAME-1));
        end
    endtask

    task automatic expect_idle(input bit sel, input string tag);
        logic xs, xv, sf, ls, bz, rd;
        @(negedge CLK);
        sample(sel, xs, xv, sf, ls, bz, rd);
        check({tag, ".x"},     xs, 1'b0);
        check({tag, ".valid"}, xv, 1'b0);
        check({tag, ".sof"},   sf, 1'b0);
        check({tag, ".last"},  ls, 1'b0);
        check({tag, ".busy"},  bz, 1'b0);
        check({tag, ".ready"}, rd, 1'b1);
    endtask

    initial begin
        RST = 1'b1;
        drive(0, '0, 1'b0);
        drive(1, '0, 1'b0);

        // 1: reset values, then release
        @(negedge CLK);
        check("rst.x",     x_m,    1'b0);
        check("rst.valid", xv_m,   1'b0);
        check("rst.sof",   sof_m,  1'b0);
        check("rst.last",  last_m, 1'b0);
        check("rst.busy",  busy_m, 1'b0);
        check("rst.ready", rdy_m,  1'b0);
        RST = 1'b0;
        #1;
        check("rel.ready", rdy_m,  1'b1);
        check("rel.x",     x_m,    1'b0);
        check("rel.valid", xv_m,   1'b0);
        check("rel.busy",  busy_m, 1'b0);

        // 2: single word D0, MSB first -> 1101 0000
        @(negedge CLK);
        drive(0, 8'hD0, 1'b1);
        expect_frame(0, 8'hD0, 1'b0, 8'h00, "t2");
        expect_idle(0, "t2.idle");

        // 3: back-to-back A5 then 3C; din changes mid-frame and must be ignored
        drive(0, 8'hA5, 1'b1);
        expect_frame(0, 8'hA5, 1'b1, 8'h3C, "t3a");
        expect_frame(0, 8'h3C, 1'b0, 8'h00, "t3b");
        expect_idle(0, "t3.idle");

        // 4: LSB-first instance, 0B -> 1101 0000
        drive(1, 8'h0B, 1'b1);
        expect_frame(1, 8'h0B, 1'b0, 8'h00, "t4");
        expect_idle(1, "t4.idle");

        // 5: reset during the 3rd bit of FF, then 80 after release
        drive(0, 8'hFF, 1'b1);
        @(negedge CLK);
        drive(0, 8'h00, 1'b0);
        check("t5.x[0]", x_m, 1'b1);
        @(negedge CLK);
        @(negedge CLK);
        check("t5.x[2]",     x_m,  1'b1);
        check("t5.valid[2]", xv_m, 1'b1);
        RST = 1'b1;
        #1;
        check("t5.rst.x",     x_m,    1'b0);
        check("t5.rst.valid", xv_m,   1'b0);
        check("t5.rst.busy",  busy_m, 1'b0);
        check("t5.rst.sof",   sof_m,  1'b0);
        check("t5.rst.last",  last_m, 1'b0);
        check("t5.rst.ready", rdy_m,  1'b0);
        @(negedge CLK);
        RST = 1'b0;
        check("t5.rel.valid", xv_m, 1'b0);
        drive(0, 8'h80, 1'b1);
        expect_frame(0, 8'h80, 1'b0, 8'h00, "t5b");
        expect_idle(0, "t5.idle");

`ifdef SER_PARITY_EN
        // 6: 07 -> 0000 0111 then parity 1; accept in the parity cycle
        drive(0, 8'h07, 1'b1);
        expect_frame(0, 8'h07, 1'b1, 8'h0B, "t6a");
        expect_frame(0, 8'h0B, 1'b0, 8'h00, "t6b");
        expect_idle(0, "t6.idle");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
